// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair
module hilo_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic             hiwrite_i,
  input  logic             lowrite_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             divzero_o
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state, nextState;
  logic                 accept, inSigned, isDivOp, bZero;
  logic [WIDTH-1:0]     aMag, bMag;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     opA, opB, quot, rem, divisor;
  logic                 opSigned, negQ, negR, divZero;
  logic [2*WIDTH-1:0]   extA, extB, product;
  logic [WIDTH:0]       shifted, diff;

  assign accept   = start_i & ~cancel_i & (state == IDLE);
  assign isDivOp  = op_i[1];
  assign inSigned = ~op_i[0];
  assign bZero    = (b_i == '0);
  assign aMag     = (inSigned & a_i[WIDTH-1]) ? -a_i : a_i;
  assign bMag     = (inSigned & b_i[WIDTH-1]) ? -b_i : b_i;

  // Full-width product of the extended operands; only the low 2*WIDTH bits matter.
  assign extA    = {{WIDTH{opSigned & opA[WIDTH-1]}}, opA};
  assign extB    = {{WIDTH{opSigned & opB[WIDTH-1]}}, opB};
  assign product = extA * extB;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign shifted = {rem, quot[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = isDivOp ? (bZero ? FIX : DIV) : MUL;
      MUL:  if (cancel_i || count == '0) nextState = IDLE;
      DIV:  if (cancel_i) nextState = IDLE;
            else if (count == '0) nextState = FIX;
      FIX:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (start_i & ~cancel_i & (state == IDLE)) | ((state != IDLE) & ~cancel_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o      <= '0;
      lo_o      <= '0;
      done_o    <= 1'b0;
      divzero_o <= 1'b0;
      count     <= '0;
      opA       <= '0;
      opB       <= '0;
      opSigned  <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      divisor   <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      divZero   <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      divzero_o <= 1'b0;
      case (state)
        IDLE: begin
          if (hiwrite_i) hi_o <= wdata_i;
          if (lowrite_i) lo_o <= wdata_i;
          if (accept) begin
            opA      <= a_i;
            opB      <= b_i;
            opSigned <= inSigned;
            quot     <= aMag;
            rem      <= '0;
            divisor  <= bMag;
            negQ     <= inSigned & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            negR     <= inSigned & a_i[WIDTH-1];
            divZero  <= isDivOp & bZero;
            count    <= isDivOp ? CW'(WIDTH - 1) : CW'(MUL_LAT - 1);
          end
        end
        MUL: if (!cancel_i) begin
          if (count == '0) begin
            hi_o   <= product[2*WIDTH-1:WIDTH];
            lo_o   <= product[WIDTH-1:0];
            done_o <= 1'b1;
          end else begin
            count <= count - CW'(1);
          end
        end
        DIV: if (!cancel_i) begin
          if (!diff[WIDTH]) begin
            rem  <= diff[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= shifted[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          if (count != '0) count <= count - CW'(1);
        end
        FIX: if (!cancel_i) begin
          done_o <= 1'b1;
          if (divZero) begin
            divzero_o <= 1'b1;
          end else begin
            lo_o <= negQ ? -quot : quot;
            hi_o <= negR ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - scoreboard bench for hilo_muldiv
module tb_hilo_muldiv;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst, start, cancel, hiwrite, lowrite;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata, hi, lo;
  logic         busy, done, divzero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;
  exp_t expQ[$];

  hilo_muldiv #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .cancel_i(cancel), .hiwrite_i(hiwrite), .lowrite_i(lowrite), .wdata_i(wdata),
    .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done), .divzero_o(divzero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("sb_hi", hi, e.hi);
          check("sb_lo", lo, e.lo);
          check("sb_divzero", {31'b0, divzero}, {31'b0, e.dz});
        end
      end else if (divzero) begin
        tests++;
        fails++;
        $display("FAIL divzero_without_done: got divzero=1 expected 0 at %0t", $time);
      end
    end
  end

  // Caller has driven start in cycle 0 and sampled it; walks cycles 1..lat and the done cycle.
  task automatic waitDone(input int lat);
    tick();
    start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", c), {31'b0, busy}, 32'd1);
      check($sformatf("early_done_c%0d", c), {31'b0, done}, 32'd0);
      tick();
    end
    @(negedge clk);
    check("busy_done_cycle", {31'b0, busy}, 32'd0);
    check("done_cycle", {31'b0, done}, 32'd1);
    tick();
  endtask

  task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                       input int lat);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz;
    expQ.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    check("busy_c0", {31'b0, busy}, 32'd1);
    waitDone(lat);
  endtask

  task automatic mtWrite(input logic isHi, input logic [W-1:0] d);
    hiwrite = isHi; lowrite = ~isHi; wdata = d;
    @(negedge clk);
    check("busy_mt", {31'b0, busy}, 32'd0);
    tick();
    hiwrite = 1'b0; lowrite = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; hiwrite = 1'b0; lowrite = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    tick();

    mtWrite(1'b1, 32'h1234);
    mtWrite(1'b0, 32'h5678);
    @(negedge clk);
    check("mthi", hi, 32'h00001234);
    check("mtlo", lo, 32'h00005678);
    tick();

    runOp(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, LAT);
    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT);
    runOp(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, LAT);
    runOp(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W + 1);
    runOp(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, W + 1);
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, W + 1);
    runOp(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, W + 1);
    runOp(2'b11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF, 1'b0, W + 1);

    mtWrite(1'b1, 32'hAA);
    mtWrite(1'b0, 32'hBB);
    runOp(2'b11, 32'd100, 32'd0, 32'hAA, 32'hBB, 1'b1, 1);

    // DIV cancelled in cycle 10, with an ignored MTLO in cycle 5.
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      lowrite = (c == 5);
      wdata   = 32'hDEAD;
      cancel  = (c == 10);
      @(negedge clk);
      check($sformatf("cancel_busy_c%0d", c), {31'b0, busy}, (c == 10) ? 32'd0 : 32'd1);
      tick();
    end
    lowrite = 1'b0; cancel = 1'b0;
    begin
      exp_t e;
      e.hi = 32'h0; e.lo = 32'd42; e.dz = 1'b0;
      expQ.push_back(e);
    end
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    @(negedge clk);
    check("after_cancel_hi", hi, 32'hAA);
    check("after_cancel_lo", lo, 32'hBB);
    check("after_cancel_busy", {31'b0, busy}, 32'd1);
    check("after_cancel_done", {31'b0, done}, 32'd0);
    waitDone(LAT);

    // Reset mid-operation clears HI/LO and produces no done.
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midreset_hi", hi, 32'h0);
    check("midreset_lo", lo, 32'h0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    for (int c = 0; c < 4; c++) tick();

    check("queue_drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
